// File: rtl/mem_stream_pkg.sv
// Shared types and defaults for the memory read streamer.
// The optional stall counter is enabled by MEM_READ_STREAMER_STATS_EN.
package mem_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_LAT   = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bits needed to hold every value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_read_streamer_chk.sv
// Protocol checks for the read streamer: parameter legality and
// unexpected memory returns (while idle, or into a full buffer).
module mem_read_streamer_chk #(
  parameter int unsigned DATA_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic idle,
  input logic r_dvalid,
  input logic fifo_full
);

  if (DATA_LAT < 1 || FIFO_DEPTH < 1) begin : g_bad_param
    $error("mem_read_streamer: DATA_LAT and FIFO_DEPTH must be >= 1");
  end

  a_no_return_idle : assert property (@(posedge clk) disable iff (rst) !(r_dvalid && idle));
  a_no_overflow    : assert property (@(posedge clk) disable iff (rst) !(r_dvalid && fifo_full));

endmodule

// File: rtl/stream_fifo.sv
// Synchronous return buffer for the read streamer.
// Data output reads as zero while empty so the stream outputs idle at zero.
module stream_fifo import mem_stream_pkg::*; #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mem_read_streamer.sv
// Credit-based burst reader: issues memory reads and streams the returns.
// Define MEM_READ_STREAMER_STATS_EN to add the stall_cnt output.
module mem_read_streamer import mem_stream_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_LAT   = DEF_DATA_LAT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef MEM_READ_STREAMER_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, len_q, len_d;
  logic [ADDR_WIDTH-1:0] iss_cnt_q, iss_cnt_d, ret_cnt_q, ret_cnt_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  issue_s, pop_s, push_s, accept_s, fifo_full_s, fifo_empty_s;

  assign issue_s  = (state_q == ST_ISSUE) && (credits_q != '0);
  assign accept_s = (state_q == ST_IDLE) && req_valid;
  assign pop_s    = out_valid && out_ready;
  assign push_s   = r_dvalid && (state_q != ST_IDLE);
  assign r_addr   = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = req_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = (issue_s && iss_cnt_q == len_q) ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_d = (pop_s && out_last) ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    r_avalid  = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: r_avalid  = issue_s;
      ST_DRAIN: r_avalid  = 1'b0;
      default:  req_ready = 1'b0;
    endcase
  end

  // A credit is held from issue until the beat leaves the buffer.
  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (accept_s) begin
      addr_d    = req_addr;
      len_d     = req_len;
      iss_cnt_d = '0;
      ret_cnt_d = '0;
    end else begin
      if (issue_s) begin
        addr_d    = addr_q + ADDR_WIDTH'(1);
        iss_cnt_d = iss_cnt_q + ADDR_WIDTH'(1);
      end else begin
        addr_d    = addr_q;
        iss_cnt_d = iss_cnt_q;
      end
      if (push_s) begin
        ret_cnt_d = ret_cnt_q + ADDR_WIDTH'(1);
      end else begin
        ret_cnt_d = ret_cnt_q;
      end
    end
    case ({issue_s, pop_s})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      credits_q <= CW'(FIFO_DEPTH);
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      credits_q <= credits_d;
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata ({r_data, ret_cnt_q == len_q}),
    .pop   (pop_s),
    .rdata ({out_data, out_last}),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;

  mem_read_streamer_chk #(
    .DATA_LAT   (DATA_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .idle      (state_q == ST_IDLE),
    .r_dvalid  (r_dvalid),
    .fifo_full (fifo_full_s)
  );

`ifdef MEM_READ_STREAMER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench for mem_read_streamer: a memory model with fixed latency,
// burst expectations computed from the memory image at request time.
module tb_mem_read_streamer;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int MEMN  = 1 << AW;
  localparam int BOUND = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr, req_len, r_addr;
  logic          r_avalid, r_dvalid;
  logic [DW-1:0] r_data, out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
`ifdef MEM_READ_STREAMER_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .r_addr(r_addr), .r_avalid(r_avalid),
    .r_dvalid(r_dvalid), .r_data(r_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
`ifdef MEM_READ_STREAMER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;

  logic [DW-1:0] mem [MEMN];
  logic [LAT-1:0] pv;
  logic [DW-1:0]  pd [LAT];
  beat_t          exp_q [$];
  logic [AW-1:0]  exp_addr_q [$];
  int tests = 0, fails = 0, issued = 0, mode = 0;

  // Memory model: fixed DATA_LAT pipeline, flushed by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= r_avalid;
      pd[0] <= mem[r_addr];
    end
  end
  assign r_dvalid = pv[LAT-1];
  assign r_data   = pd[LAT-1];

  // Consumer: 0 always ready, 1 toggling, 2 random, 3 stalled.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = !out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: addresses, beats, stability under backpressure, ready after last.
  logic       prev_stall = 1'b0, last_seen = 1'b0;
  logic [DW:0] prev_beat;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      last_seen  = 1'b0;
    end else begin
      if (last_seen) begin
        check("req_ready_after_last", req_ready, 1);
        last_seen = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", {out_data, out_last}, prev_beat);
      end
      if (r_avalid) begin
        issued++;
        check("issue_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check("r_addr", r_addr, exp_addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          if (out_last) last_seen = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_last};
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("req_wait_bounded", n < BOUND, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk);
    for (int k = 0; k <= int'(l); k++) begin
      logic [AW-1:0] ad;
      ad = AW'(int'(a) + k);
      exp_addr_q.push_back(ad);
      exp_q.push_back('{data: mem[ad], last: (k == int'(l))});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && exp_addr_q.size() == 0 && req_ready) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("burst_done_bounded", n < BOUND, 1);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < MEMN; i++) mem[i] = DW'(i + 100);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_r_avalid"}, r_avalid, 0);
    check({tag, "_r_addr"}, r_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    int k, base, run;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;
    fill_linear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("reset_req_ready", req_ready, 1);

    // Linear image: beats 102..105, first beat latency 2+DATA_LAT.
    mode = 0;
    send(4'd2, 4'd3);
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("first_beat_latency", k, 2 + LAT);
    check("first_beat_value", out_data, 102);
    wait_done();

    // Address wrap 14,15,0,1.
    send(4'd14, 4'd3);
    wait_done();

    // Full-length burst at full rate: out_valid stays high for 16 cycles.
    send(4'd0, 4'd15);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    run = 0;
    while (out_valid && run < 40) begin
      run++;
      @(negedge clk);
    end
    check("full_rate_run", run, 16);
    wait_done();

    // Stalled consumer: credits cap the issued reads at FIFO_DEPTH.
    mode = 3;
    base = issued;
    send(4'd0, 4'd7);
    repeat (10) @(negedge clk);
    check("issued_while_stalled", issued - base, DEPTH);
    check("r_avalid_blocked", r_avalid, 0);
    mode = 0;
    wait_done();

    // Toggling consumer plus a back-to-back second request.
    mode = 1;
    send(4'd5, 4'd15);
    send(4'd9, 4'd2);
    wait_done();

    // Reset during DRAIN discards everything, then a fresh burst works.
    mode = 3;
    send(4'd1, 4'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check_reset_outputs("midburst_reset");
    repeat (LAT + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", req_ready, 1);
    mode = 0;
    send(4'd12, 4'd5);
    wait_done();

    // Randomized bursts over random memory images and consumer behaviour.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < MEMN; i++) mem[i] = $urandom;
      mode = $urandom_range(0, 2);
      send(AW'($urandom), AW'($urandom));
      wait_done();
    end
    mode = 0;

`ifdef MEM_READ_STREAMER_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode = 3;
    send(4'd0, 4'd0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check("stall_cnt_5", stall_cnt, 5);
    repeat (70000) @(negedge clk);
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    mode = 0;
    wait_done();
`endif

    check("leftover_beats", exp_q.size(), 0);
    check("leftover_addrs", exp_addr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
